// File: rtl/dct_block_sequencer.sv
// 8x8 2D-DCT coefficient sequencer: sweeps 64 samples per coefficient through a
// pixel x cosine multiply-accumulate pipeline and hands out one rounded, saturated coefficient at a time.
module dct_block_sequencer #(
  parameter int DATA_W    = 9,
  parameter int COS_W     = 32,
  parameter int FRAC_BITS = 10,
  parameter int ACC_W     = 48,
  parameter int OUT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               lut_k1,
  output logic [2:0]               lut_k2,
  output logic [2:0]               lut_n1,
  output logic [2:0]               lut_n2,
  input  logic signed [COS_W-1:0]  cos_term,
  output logic                     pix_rd_en,
  output logic [5:0]               pix_addr,
  input  logic signed [DATA_W-1:0] pix_data,
  output logic                     coef_valid,
  input  logic                     coef_ready,
  output logic signed [OUT_W-1:0]  coef_data,
  output logic [2:0]               coef_k1,
  output logic [2:0]               coef_k2
);
  localparam int PROD_W = DATA_W + COS_W;
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t                    state_q, state_d;
  logic [5:0]                n_q, n_d, k_q, k_d, coef_k_q, coef_k_d;
  logic                      drain_q, drain_d, rd_q, rd_d;
  logic                      busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic [1:0]                vld_pipe_q, vld_pipe_d, first_pipe_q, first_pipe_d;
  logic signed [COS_W-1:0]   cos_q, cos_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d, acc_sum, rnd, shifted;
  logic signed [OUT_W-1:0]   coef_q, coef_d, coef_sat;

  // vld_pipe[0]: pix_data/cos_q hold a sample; vld_pipe[1]: prod_q holds a product.
  always_comb begin
    vld_pipe_d   = {vld_pipe_q[0], rd_q};
    first_pipe_d = {first_pipe_q[0], rd_q && (n_q == 6'd0)};
    cos_d        = cos_term;
    prod_d       = vld_pipe_q[0] ? PROD_W'(pix_data) * PROD_W'(cos_q) : prod_q;
    acc_sum      = acc_q;
    if (vld_pipe_q[1])
      acc_sum = first_pipe_q[1] ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
  end

  // Rounding uses the accumulator's next value so the coefficient is ready
  // on the first OUT cycle without an extra stage.
  always_comb begin
    rnd     = acc_sum + RND_HALF;
    shifted = rnd >>> FRAC_BITS;
    if (shifted > SAT_MAX)      coef_sat = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN) coef_sat = SAT_MIN[OUT_W-1:0];
    else                        coef_sat = shifted[OUT_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    k_d      = k_q;
    drain_d  = drain_q;
    acc_d    = acc_sum;
    coef_d   = coef_q;
    coef_k_d = coef_k_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // done_q marks the cycle right after a block; start is not honoured there.
        if (start && !done_q) begin
          state_d = ACCUM;
          n_d     = 6'd0;
          k_d     = 6'd0;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        n_d = n_q + 6'd1;
        if (n_q == 6'd63) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d  = OUT;
          coef_d   = coef_sat;
          coef_k_d = k_q;
          valid_d  = 1'b1;
        end
      end
      OUT: begin
        if (coef_ready) begin
          valid_d = 1'b0;
          n_d     = 6'd0;
          if (k_q == 6'd63) begin
            state_d = IDLE;
            k_d     = 6'd0;
            done_d  = 1'b1;
          end else begin
            state_d = ACCUM;
            k_d     = k_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    rd_d   = (state_d == ACCUM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      k_q          <= '0;
      drain_q      <= 1'b0;
      rd_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
      cos_q        <= '0;
      prod_q       <= '0;
      acc_q        <= '0;
      coef_q       <= '0;
      coef_k_q     <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      k_q          <= k_d;
      drain_q      <= drain_d;
      rd_q         <= rd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
      vld_pipe_q   <= vld_pipe_d;
      first_pipe_q <= first_pipe_d;
      cos_q        <= cos_d;
      prod_q       <= prod_d;
      acc_q        <= acc_d;
      coef_q       <= coef_d;
      coef_k_q     <= coef_k_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pix_rd_en  = rd_q;
  assign pix_addr   = n_q;
  assign lut_n1     = n_q[5:3];
  assign lut_n2     = n_q[2:0];
  assign lut_k1     = k_q[5:3];
  assign lut_k2     = k_q[2:0];
  assign coef_valid = valid_q;
  assign coef_data  = coef_q;
  assign coef_k1    = coef_k_q[5:3];
  assign coef_k2    = coef_k_q[2:0];
endmodule

// File: tb/tb_dct_block_sequencer.sv
// Directed bench for dct_block_sequencer: behavioural LUT and 1-cycle pixel RAM,
// table of whole-block vectors plus hand-written reset / backpressure / start-ignore sequences.
module tb_dct_block_sequencer;
  localparam int DATA_W = 9, COS_W = 32, FRAC_BITS = 10, ACC_W = 48, OUT_W = 16;

  logic clk = 1'b0;
  logic reset, start, busy, done, pix_rd_en, coef_valid, coef_ready;
  logic [2:0] lut_k1, lut_k2, lut_n1, lut_n2, coef_k1, coef_k2;
  logic [5:0] pix_addr;
  logic signed [COS_W-1:0]  cos_term;
  logic signed [DATA_W-1:0] pix_data = '0;
  logic signed [OUT_W-1:0]  coef_data;

  dct_block_sequencer #(.DATA_W(DATA_W), .COS_W(COS_W), .FRAC_BITS(FRAC_BITS),
                        .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .lut_k1(lut_k1), .lut_k2(lut_k2), .lut_n1(lut_n1), .lut_n2(lut_n2),
    .cos_term(cos_term), .pix_rd_en(pix_rd_en), .pix_addr(pix_addr),
    .pix_data(pix_data), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_data(coef_data), .coef_k1(coef_k1), .coef_k2(coef_k2));

  always #5 clk = ~clk;

  // LUT mode 0: constant term; mode 1: 1.0 only where (n1,n2)==(k1,k2).
  int          lut_mode = 0;
  logic [31:0] cos_val  = '0;
  int          pix_mode = 0;
  int          pix_val  = 0;

  always_comb begin
    cos_term = cos_val;
    if (lut_mode == 1)
      cos_term = (lut_n1 == lut_k1 && lut_n2 == lut_k2) ? 32'sd1024 : 32'sd0;
  end

  // Pixel mode 1 stores addr-32 at each address.
  always @(posedge clk)
    if (pix_rd_en)
      pix_data <= (pix_mode == 1) ? 9'(int'(pix_addr) - 32) : 9'(pix_val);

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, pix_rd_en, 0);
    chk({tag, "_valid"}, coef_valid, 0);
    chk({tag, "_addr"}, pix_addr, 0);
    chk({tag, "_lut"}, {lut_k1, lut_k2, lut_n1, lut_n2}, 0);
    chk({tag, "_coef_k"}, {coef_k1, coef_k2}, 0);
    chk({tag, "_coef_data"}, coef_data, 0);
  endtask

  typedef struct {
    string       name;
    int          lmode;
    logic [31:0] cosv;
    int          pmode;
    int          pval;
    int          expv;
  } vec_t;
  vec_t tbl[6];

  task automatic set_vec(input int vi);
    lut_mode = tbl[vi].lmode;
    cos_val  = tbl[vi].cosv;
    pix_mode = tbl[vi].pmode;
    pix_val  = tbl[vi].pval;
  endtask

  // Runs one block from start to a few cycles past done. stress adds a 10-cycle
  // stall at (0,3) and start pulses in ACCUM, DRAIN, OUT and on the done cycle.
  task automatic run_block(input int vi, input bit timing, input bit stress);
    int cyc, hs, done_cnt, done_cyc, first_v, stall, post, expv;
    bit prev_hs, prev_v;
    logic signed [OUT_W-1:0] held_d;
    logic [5:0] held_k;
    string nm;
    nm = tbl[vi].name;
    set_vec(vi);
    coef_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk({nm, "_busy_rise"}, busy, 1);
    hs = 0; done_cnt = 0; done_cyc = -1; first_v = -1; stall = 0; post = 0;
    prev_hs = 0; prev_v = 0; held_d = '0; held_k = '0;
    while (post < 3 && cyc < 6000) begin
      coef_ready = 1'b1;
      if (stress && coef_valid && coef_k1 == 3'd0 && coef_k2 == 3'd3 && stall < 10) begin
        coef_ready = 1'b0;
        stall++;
      end
      start = stress && (cyc == 10 || cyc == 65 || cyc == 66 || cyc == 67 ||
                         (coef_valid && !coef_ready) || done);
      if (coef_valid && first_v < 0) first_v = cyc;
      if (coef_valid && !prev_v) begin
        held_d = coef_data;
        held_k = {coef_k1, coef_k2};
      end
      if (coef_valid && prev_v) begin
        chk({nm, "_hold_data"}, coef_data, held_d);
        chk({nm, "_hold_k"}, {coef_k1, coef_k2}, held_k);
        chk({nm, "_hold_rd_en"}, pix_rd_en, 0);
      end
      if (prev_hs) begin
        chk({nm, "_valid_drop"}, coef_valid, 0);
        if (hs < 64) begin
          chk({nm, "_next_rd_en"}, pix_rd_en, 1);
          chk({nm, "_next_addr"}, pix_addr, 0);
          chk({nm, "_next_lut_k"}, {lut_k1, lut_k2}, hs);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0) begin
        chk({nm, "_busy_low"}, busy, 0);
        post++;
      end
      prev_hs = coef_valid && coef_ready;
      if (prev_hs) begin
        expv = (tbl[vi].pmode == 1) ? hs - 32 : tbl[vi].expv;
        chk({nm, "_coef_data"}, coef_data, expv);
        chk({nm, "_coef_k"}, {coef_k1, coef_k2}, hs);
        hs++;
      end
      prev_v = coef_valid;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    coef_ready = 1'b1;
    chk({nm, "_finished_in_budget"}, post, 3);
    chk({nm, "_handshakes"}, hs, 64);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    if (timing) begin
      chk({nm, "_first_valid_cycle"}, first_v, 67);
      chk({nm, "_done_cycle"}, done_cyc, 4289);
    end
    if (stress) begin
      chk({nm, "_stall_cycles"}, stall, 10);
      chk({nm, "_done_cycle"}, done_cyc, 4299);
    end
  endtask

  initial begin
    int bad_ev;
    tbl[0] = '{"unity",    0, 32'd1024,       0,   10,    640};
    tbl[1] = '{"rnd_pos",  0, 32'd180,        0,  127,   1429};
    tbl[2] = '{"rnd_neg",  0, 32'd180,        0, -128,  -1440};
    tbl[3] = '{"sat_pos",  0, 32'h7fffffff,   0,  127,  32767};
    tbl[4] = '{"sat_neg",  0, 32'h7fffffff,   0, -128, -32768};
    tbl[5] = '{"diag",     1, 32'd0,          1,    0,      0};

    reset = 1'b1; start = 1'b0; coef_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst_state");
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("idle");

    // Reset asserted for 3 cycles starting in cycle 30 of a sweep.
    set_vec(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) begin @(posedge clk); #1; end
    chk("pre_rst_rd_en", pix_rd_en, 1);
    chk("pre_rst_addr", pix_addr, 29);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("mid_rst");
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    bad_ev = 0;
    repeat (100) begin
      if (done || coef_valid || busy || pix_rd_en) bad_ev++;
      @(posedge clk); #1;
    end
    chk("post_rst_quiet", bad_ev, 0);

    for (int i = 0; i < 6; i++) run_block(i, i == 0, 1'b0);
    run_block(5, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
